// File: rtl/mult_div_ctrl_if.sv
// Command/result bundle between the EX stage and the multiply/divide unit.
interface mult_div_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, md_use,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, md_use,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers and stall request.
// Operands are latched at issue; the result is formed from the latched
// operands and committed to HI/LO on the last edge of the busy window.
module mult_div_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mult_div_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state;
    logic [3:0]  cnt;
    op_e         op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        res_we;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Result datapath from latched operands; signed divide works on
    // magnitudes so 0x80000000 / -1 wraps to 0x80000000 without a special case.
    always_comb begin
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        a_neg  = (op_q == OP_DIV) & a_q[31];
        b_neg  = (op_q == OP_DIV) & b_q[31];
        mag_a  = a_neg ? (~a_q + 32'd1) : a_q;
        mag_b  = b_neg ? (~b_q + 32'd1) : b_q;
        q_mag  = '0;
        r_mag  = '0;
        if (b_q != '0) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
        res_we = 1'b0;
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT: begin
                res_we = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            OP_MULTU: begin
                res_we = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            OP_DIV, OP_DIVU: begin
                res_we = (b_q != '0);
                res_hi = rem;
                res_lo = quot;
            end
            default: res_we = 1'b0;
        endcase
    end

    // Sequencing FSM: issue in IDLE, count down in RUN, commit on the final edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= OP_MULT;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (!bus.op[2]) begin
                            op_q   <= op_e'(bus.op);
                            a_q    <= bus.a;
                            b_q    <= bus.b;
                            cnt    <= bus.op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end else if (bus.op == OP_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                RUN: begin
                    if (cnt == 4'd1) begin
                        if (res_we) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.stall = bus.md_use & (busy_q | (bus.start & ~bus.op[2]));

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized self-checking bench for mult_div_ctrl with an arithmetic model.
module tb_mult_div_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_ctrl_if md_if ();

    mult_div_ctrl #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (md_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one accepted command on HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        longint      q, r;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd0: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd1: begin p = 64'(ua * ub); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                exp_lo = q[31:0]; exp_hi = r[31:0];
            end
            3'd3: if (b != 0) begin
                q = ua / ub; r = ua % ub;
                exp_lo = q[31:0]; exp_hi = r[31:0];
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic use_bit;
        int   n;
        use_bit      = 1'($urandom_range(0, 1));
        md_if.start  = 1'b1;
        md_if.op     = op;
        md_if.a      = a;
        md_if.b      = b;
        md_if.md_use = use_bit;
        #1 check("stall_issue", md_if.stall, use_bit & ~op[2]);
        step();
        md_if.start = 1'b0;
        if (!op[2]) begin
            n = op[1] ? DC : MC;
            for (int s = 0; s < n; s++) begin
                md_if.md_use = 1'($urandom_range(0, 1));
                #1;
                check("busy_run", md_if.busy, 1);
                check("done_run", md_if.done, 0);
                check("hi_hold", md_if.hi, exp_hi);
                check("lo_hold", md_if.lo, exp_lo);
                check("stall_run", md_if.stall, md_if.md_use);
                step();
            end
            model(op, a, b);
            check("busy_end", md_if.busy, 0);
            check("done_pulse", md_if.done, 1);
            check("hi_res", md_if.hi, exp_hi);
            check("lo_res", md_if.lo, exp_lo);
            step();
            check("done_clr", md_if.done, 0);
            check("busy_idle", md_if.busy, 0);
        end else begin
            model(op, a, b);
            check("hi_mt", md_if.hi, exp_hi);
            check("lo_mt", md_if.lo, exp_lo);
            check("busy_mt", md_if.busy, 0);
            check("done_mt", md_if.done, 0);
        end
        md_if.md_use = 1'b0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset        = 1'b0;
        md_if.start  = 1'b0;
        md_if.op     = '0;
        md_if.a      = '0;
        md_if.b      = '0;
        md_if.md_use = 1'b0;
        exp_hi       = '0;
        exp_lo       = '0;
        repeat (3) step();
        check("rst_busy", md_if.busy, 0);
        check("rst_done", md_if.done, 0);
        check("rst_hi", md_if.hi, 0);
        check("rst_lo", md_if.lo, 0);
        reset = 1'b1;
        step();

        run_cmd(3'd0, 32'hFFFFFFFE, 32'd3);
        check("t1_hi", md_if.hi, 32'hFFFFFFFF);
        check("t1_lo", md_if.lo, 32'hFFFFFFFA);
        run_cmd(3'd1, 32'hFFFFFFFE, 32'd3);
        check("t2_hi", md_if.hi, 32'h00000002);
        check("t2_lo", md_if.lo, 32'hFFFFFFFA);
        run_cmd(3'd2, 32'hFFFFFFF9, 32'd2);
        check("t3a_hi", md_if.hi, 32'hFFFFFFFF);
        check("t3a_lo", md_if.lo, 32'hFFFFFFFD);
        run_cmd(3'd3, 32'd7, 32'd2);
        check("t3b_hi", md_if.hi, 32'd1);
        check("t3b_lo", md_if.lo, 32'd3);
        run_cmd(3'd2, 32'h80000000, 32'hFFFFFFFF);
        check("t3c_hi", md_if.hi, 32'h00000000);
        check("t3c_lo", md_if.lo, 32'h80000000);
        run_cmd(3'd4, 32'h12345678, 32'd0);
        run_cmd(3'd5, 32'h9ABCDEF0, 32'd0);
        run_cmd(3'd2, 32'd55, 32'd0);
        check("t4_hi", md_if.hi, 32'h12345678);
        check("t4_lo", md_if.lo, 32'h9ABCDEF0);
        run_cmd(3'd6, 32'hDEADBEEF, 32'd1);
        check("rsv_busy", md_if.busy, 0);

        // Command presented while busy must be ignored; stall holds throughout.
        md_if.start = 1'b1; md_if.op = 3'd0; md_if.a = 32'd1234; md_if.b = 32'hFFFFFF00;
        step();
        md_if.start = 1'b0;
        for (int s = 0; s < MC; s++) begin
            if (s >= 1 && s <= MC - 2) begin
                md_if.start = 1'b1; md_if.op = 3'd2; md_if.a = $urandom; md_if.b = 32'd3;
            end else begin
                md_if.start = 1'b0;
            end
            md_if.md_use = (s >= 1);
            #1;
            check("t5_busy", md_if.busy, 1);
            if (s >= 1) check("t5_stall", md_if.stall, 1);
            step();
        end
        model(3'd0, 32'd1234, 32'hFFFFFF00);
        check("t5_done", md_if.done, 1);
        check("t5_busy_end", md_if.busy, 0);
        check("t5_stall_end", md_if.stall, 0);
        check("t5_hi", md_if.hi, exp_hi);
        check("t5_lo", md_if.lo, exp_lo);
        step();
        check("t5_no_div", md_if.busy, 0);
        md_if.md_use = 1'b0;

        // Asynchronous reset in the middle of a divide.
        md_if.start = 1'b1; md_if.op = 3'd3; md_if.a = 32'd1000; md_if.b = 32'd7;
        step();
        md_if.start = 1'b0;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check("t6_busy", md_if.busy, 0);
        check("t6_hi", md_if.hi, 0);
        check("t6_lo", md_if.lo, 0);
        for (int s = 0; s < DC; s++) begin
            step();
            check("t6_done", md_if.done, 0);
        end
        #3 reset = 1'b1;
        step();
        run_cmd(3'd0, 32'h00010001, 32'h00010001);
        check("t6_mult_lo", md_if.lo, 32'h00020001);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_cmd(rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
